// File: rtl/jk_bank_ctrl_pkg.sv
// Shared op codes, FSM state encoding and helpers for the JK bank controller.
package jk_bank_ctrl_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_APPLY = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/jk_bank_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; after any grant the other input gets priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // ptr_q = 0 favours req[0], 1 favours req[1]
  logic ptr_q;

  assign gnt[0] = req[0] & (~req[1] | ~ptr_q);
  assign gnt[1] = req[1] & (~req[0] |  ptr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (adv) begin
      ptr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Sequencer sharing an external JK flip-flop bank between two requesters, one command in flight.
// Optional JK_CTRL_STATS_EN adds saturating per-requester grant counters gnt_cnt0/gnt_cnt1.
module jk_bank_ctrl
  import jk_bank_ctrl_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IDXW-1:0]  req0_idx,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IDXW-1:0]  req1_idx,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_src,
  output logic             rsp_q,
  output logic             rsp_err,
  output logic [NBITS-1:0] bank_j,
  output logic [NBITS-1:0] bank_k,
  input  logic [NBITS-1:0] bank_q,
`ifdef JK_CTRL_STATS_EN
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1,
`endif
  output logic             init_done
);

  state_e            state_q, state_d;
  logic              idle;
  logic              accept;
  logic [1:0]        arb_req;
  logic [1:0]        gnt;
  logic [IDXW-1:0]   win_idx;
  logic [1:0]        win_op;
  logic              src_q;
  logic [IDXW-1:0]   idx_q;
  logic [1:0]        op_q;
  logic [NBITS-1:0]  sel;
  logic              j_bit, k_bit;
  logic              rsp_src_q, rsp_qbit_q, rsp_err_q, init_done_q;

  // Gating with rst keeps ready low while reset would discard the command.
  assign idle    = (state_q == ST_IDLE) && !rst;
  assign arb_req = {req1_valid, req0_valid} & {2{idle}};
  assign accept  = |gnt;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .adv (accept),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign win_idx    = gnt[1] ? req1_idx : req0_idx;
  assign win_op     = gnt[1] ? req1_op  : req0_op;

  // Out-of-range indices decode to an all-zero select: no drive, error flagged.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NBITS; i++) begin
      sel[i] = (idx_q == IDXW'(i));
    end
  end

  always_comb begin
    j_bit = 1'b0;
    k_bit = 1'b0;
    case (op_q)
      OP_HOLD: begin j_bit = 1'b0; k_bit = 1'b0; end
      OP_CLR:  begin j_bit = 1'b0; k_bit = 1'b1; end
      OP_SET:  begin j_bit = 1'b1; k_bit = 1'b0; end
      OP_TOG:  begin j_bit = 1'b1; k_bit = 1'b1; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    bank_j  = '0;
    bank_k  = '0;
    case (state_q)
      ST_INIT: begin
        bank_k  = '1;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        bank_j  = sel & {NBITS{j_bit}};
        bank_k  = sel & {NBITS{k_bit}};
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_done_q <= 1'b0;
      rsp_src_q   <= 1'b0;
      rsp_qbit_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) init_done_q <= 1'b1;
      if (state_q == ST_CAPT) begin
        rsp_src_q  <= src_q;
        rsp_qbit_q <= |(sel & bank_q);
        rsp_err_q  <= ~|sel;
      end
    end
  end

  // Command fields are captured only in the accept cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      src_q <= gnt[1];
      idx_q <= win_idx;
      op_q  <= win_op;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_src   = rsp_src_q;
  assign rsp_q     = rsp_qbit_q;
  assign rsp_err   = rsp_err_q;
  assign init_done = init_done_q;

`ifdef JK_CTRL_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt[0]) cnt0_q <= sat_inc16(cnt0_q);
      if (gnt[1]) cnt1_q <= sat_inc16(cnt1_q);
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl with a behavioural JK bank and a bit-array reference model.
module tb_jk_bank_ctrl;

  localparam int NB = 6;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [IW-1:0] req0_idx, req1_idx;
  logic [1:0]    req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_src, rsp_q, rsp_err;
  logic [NB-1:0] bank_j, bank_k, bank_q;
  logic          init_done;
`ifdef JK_CTRL_STATS_EN
  logic [15:0]   gnt_cnt0, gnt_cnt1;
`endif

  always #5 clk = ~clk;

  jk_bank_ctrl #(.NBITS(NB), .IDXW(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_idx   (req0_idx),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_idx   (req1_idx),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_src    (rsp_src),
    .rsp_q      (rsp_q),
    .rsp_err    (rsp_err),
    .bank_j     (bank_j),
    .bank_k     (bank_k),
    .bank_q     (bank_q),
`ifdef JK_CTRL_STATS_EN
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1),
`endif
    .init_done  (init_done)
  );

  // External JK bank
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      case ({bank_j[i], bank_k[i]})
        2'b01:   bank_q[i] <= 1'b0;
        2'b10:   bank_q[i] <= 1'b1;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          src;
    logic          q;
    logic          err;
    logic [NB-1:0] bank;
    int            acc;
    int            idx;
    logic [1:0]    op;
  } exp_t;

  exp_t          expq[$];
  int            glog[$];
  logic [NB-1:0] mbits;
  logic          mptr;
  int            mcnt0, mcnt1;
  int            cyc = 0;
  logic          pv, held, last_q;
  logic [2:0]    hv;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic jk_next(input logic cur, input logic [1:0] op);
    case (op)
      2'b00:   return cur;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~cur;
    endcase
  endfunction

  // Monitor: responses, bank drive, and accepts, all sampled on the falling edge
  always @(negedge clk) begin : mon
    exp_t          e;
    logic [NB-1:0] ej, ek;
    logic          got, win;
    int            ii;
    if (rsp_valid) begin
      if (!pv) begin
        if (expq.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else chk("rsp_latency", cyc, expq[0].acc + 3);
      end else if (held) begin
        chk("rsp_stable", {29'd0, rsp_src, rsp_q, rsp_err}, {29'd0, hv});
      end
      chk("no_accept_in_resp", {30'd0, req1_ready, req0_ready}, 32'd0);
      if (rsp_ready && expq.size() > 0) begin
        e = expq.pop_front();
        chk("rsp_src",  32'(rsp_src), 32'(e.src));
        chk("rsp_q",    32'(rsp_q),   32'(e.q));
        chk("rsp_err",  32'(rsp_err), 32'(e.err));
        chk("bank_state", 32'(bank_q), 32'(e.bank));
        last_q = rsp_q;
      end
      pv   = 1'b1;
      held = !rsp_ready;
      hv   = {rsp_src, rsp_q, rsp_err};
    end else begin
      if (held && !rst) chk("rsp_dropped", 32'd0, 32'd1);
      pv   = 1'b0;
      held = 1'b0;
    end

    if (init_done && !rst) begin
      ej = '0;
      ek = '0;
      if (expq.size() > 0 && cyc == expq[0].acc + 1 && expq[0].idx < NB) begin
        ej[expq[0].idx] = expq[0].op[1];
        ek[expq[0].idx] = expq[0].op[0];
      end
      if ((bank_j | bank_k | ej | ek) != '0) begin
        chk("bank_j", 32'(bank_j), 32'(ej));
        chk("bank_k", 32'(bank_k), 32'(ek));
      end
    end

    if (req0_ready || req1_ready) begin
      chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
      chk("ready_needs_valid", 32'((req0_ready & !req0_valid) | (req1_ready & !req1_valid)), 32'd0);
      win = (req0_valid && req1_valid) ? mptr : req1_valid;
      got = req1_ready;
      chk("arb_winner", 32'(got), 32'(win));
      e.src = got;
      e.idx = got ? int'(req1_idx) : int'(req0_idx);
      e.op  = got ? req1_op : req0_op;
      e.err = (e.idx >= NB);
      if (!e.err) begin
        ii = e.idx;
        mbits[ii] = jk_next(mbits[ii], e.op);
        e.q = mbits[ii];
      end else begin
        e.q = 1'b0;
      end
      e.bank = mbits;
      e.acc  = cyc;
      expq.push_back(e);
      glog.push_back(int'(got));
      mptr = ~got;
      if (got) mcnt1++; else mcnt0++;
    end
  end

  // Caller is just past a rising edge; rst is sampled from the next edge on.
  task automatic do_reset();
    rst = 1'b1;
    expq.delete();
    mbits = '0;
    mptr  = 1'b0;
    mcnt0 = 0;
    mcnt1 = 0;
    pv    = 1'b0;
    held  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rsp_fields", {29'd0, rsp_src, rsp_q, rsp_err}, 32'd0);
    chk("rst_bank_k", 32'(bank_k), (32'd1 << NB) - 32'd1);
    chk("rst_bank_j", 32'(bank_j), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_bank_k", 32'(bank_k), (32'd1 << NB) - 32'd1);
    chk("init_done_low", 32'(init_done), 32'd0);
    @(posedge clk);
    #1;
    chk("init_done_high", 32'(init_done), 32'd1);
    chk("init_bank_q", 32'(bank_q), 32'(mbits));
  endtask

  task automatic send(input bit p, input logic [IW-1:0] idx, input logic [1:0] op);
    int  n;
    bit  rdy;
    n = 0;
    @(posedge clk);
    #1;
    if (p) begin req1_valid = 1'b1; req1_idx = idx; req1_op = op; end
    else   begin req0_valid = 1'b1; req0_idx = idx; req0_op = op; end
    do begin
      @(negedge clk);
      n++;
      rdy = p ? req1_ready : req0_ready;
    end while (!rdy && n < 300);
    if (!rdy) chk(p ? "accept_timeout1" : "accept_timeout0", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    // Scramble fields after acceptance; the DUT must ignore them.
    if (p) begin req1_valid = 1'b0; req1_idx = IW'($urandom); req1_op = 2'($urandom); end
    else   begin req0_valid = 1'b0; req0_idx = IW'($urandom); req0_op = 2'($urandom); end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp_valid();
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk("rsp_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit d0, d1;
    rst = 1'b1;
    req0_valid = 1'b0; req0_idx = '0; req0_op = '0;
    req1_valid = 1'b0; req1_idx = '0; req1_op = '0;
    rsp_ready = 1'b1;
    pv = 1'b0; held = 1'b0; last_q = 1'b0; hv = '0;
    mbits = '0; mptr = 1'b0; mcnt0 = 0; mcnt1 = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Contention straight after reset: grants alternate starting with req0
    glog.delete();
    fork
      begin send(1'b0, 3'd1, 2'b10); send(1'b0, 3'd2, 2'b10); end
      begin send(1'b1, 3'd3, 2'b11); send(1'b1, 3'd4, 2'b01); end
    join
    drain();
    chk("rr_count", glog.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < glog.size()) ? glog[i] : 99, i % 2);

    // SET / TOG / HOLD on one bit
    send(1'b0, 3'd5, 2'b10); drain();
    chk("set_q", 32'(last_q), 32'd1);
    send(1'b0, 3'd5, 2'b11); drain();
    chk("tog_q", 32'(last_q), 32'd0);
    send(1'b0, 3'd5, 2'b00); drain();
    chk("hold_q", 32'(last_q), 32'd0);

    // Back-pressure: response held, competing request waits for the handshake
    rsp_ready = 1'b0;
    send(1'b0, 3'd2, 2'b11);
    fork
      send(1'b1, 3'd0, 2'b10);
      begin
        wait_rsp_valid();
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Out-of-range indices are suppressed and flagged
    send(1'b1, 3'd7, 2'b10); drain();
    send(1'b1, 3'd6, 2'b11); drain();

    // Reset during APPLY drops the command
    send(1'b0, 3'd4, 2'b10);
    do_reset();
`ifdef JK_CTRL_STATS_EN
    chk("cnt0_after_rst", 32'(gnt_cnt0), 32'd0);
    chk("cnt1_after_rst", 32'(gnt_cnt1), 32'd0);
`endif
    repeat (4) @(posedge clk);
    #1;
    send(1'b1, 3'd4, 2'b10); drain();
    chk("post_rst_q", 32'(last_q), 32'd1);

    // Randomized traffic with random back-pressure
    d0 = 1'b0;
    d1 = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          send(1'b0, IW'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        d0 = 1'b1;
      end
      begin
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          send(1'b1, IW'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        d1 = 1'b1;
      end
      begin
        while (!(d0 && d1)) begin
          @(posedge clk);
          #1;
          rsp_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    rsp_ready = 1'b1;
    drain();

`ifdef JK_CTRL_STATS_EN
    chk("gnt_cnt0", 32'(gnt_cnt0), mcnt0);
    chk("gnt_cnt1", 32'(gnt_cnt1), mcnt1);
`endif
    chk("queue_empty", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
